direct_mapped_icache: RTL and testbench
=======================================

# direct_mapped_icache

Direct-mapped, one-word-per-line instruction cache that sits directly upstream of the instruction fetch unit and turns a fetch address into a 32-bit instruction. On a miss it drives the byte-serial memory controller, collecting four consecutive bytes, and assembles them little-endian into a word. It then installs the word into the line array and presents it to fetch. The fetch unit recomputes its PC every cycle from `valid_out`, so the lookup latency and hit signalling in this block set the fetch rate.

## Interface
- `INDEX_BITS`, 6, log2 of line count (64 lines × 4 bytes = 256 B)
- `clk_in` input 1: clock, all state on rising edge
- `rst_in` input 1: synchronous, active-high reset
- `req_pc` input 32: fetch address for next cycle; bits [1:0] ignored
- `inst_out` output 32: instruction for the currently latched PC (`cur_pc`)
- `valid_out` output 1: `inst_out` is valid this cycle
- `mem_byte` input 8: byte returned by memory controller
- `mem_valid` input 1: `mem_byte` valid this cycle
- `miss_req` output 1: a fill is in progress and a byte is requested
- `miss_addr` output 32: byte address being requested

## Operation
- Address split:
  - offset = pc[1:0] (ignored)
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2]
- Storage per line: valid bit, tag, 32-bit data.
- Every edge, `cur_pc <= req_pc`, in all states; lookup always uses `cur_pc`.
- Hit = valid[index(cur_pc)] && tag match; `inst_out` = data[index(cur_pc)].
- FSM states IDLE and FILL:
  - IDLE: `valid_out` = hit.
    - On miss: `fill_addr <= {cur_pc[31:2],2'b00}`, `cnt <= 0`, go to FILL.
    - The transition happens on the edge that ends the miss cycle.
  - FILL: `miss_req=1` and `miss_addr = {fill_addr[31:2], cnt}`.
    - Each cycle with `mem_valid=1`: write byte `cnt` of the fill buffer (`cnt=0` → bits [7:0]) and increment `cnt`.
    - On the fourth byte (`cnt==3 && mem_valid`): write valid/tag/data for `fill_addr`, then return to IDLE.
    - `valid_out` = hit on `cur_pc` during FILL, i.e. a hit under miss is served.
- `mem_valid` in IDLE is ignored. `mem_byte` is sampled only when `mem_valid=1`; gaps stall `cnt`.
- Redirect mid-fill (`cur_pc` moves to another line): the fill is not aborted. It completes into `fill_addr`'s line, then IDLE looks up the new `cur_pc`, which may miss again.
- Conflict: a fill overwrites any existing line at that index; no replacement choice.
- Reset:
  - all valid bits cleared, state IDLE, `cnt=0`, `cur_pc=0`, `fill_addr=0`
  - outputs: `valid_out=0`, `miss_req=0`, `miss_addr=0`
- Reset mid-fill drops `miss_req` on the following cycle and discards the partial line. The memory controller treats `miss_req` falling as cancel.
- Data and tag arrays are not reset; only the valid bits are.

## Timing
- Hit latency: `req_pc` presented in cycle N → `inst_out`/`valid_out` in cycle N+1 (combinational from the array on `cur_pc`).
- Miss:
  - miss seen in cycle N+1
  - `miss_req` rises in N+2
  - with memory returning one byte per cycle from N+2, the 4th byte arrives in N+5
  - `valid_out` in N+6 (N+5 with forwarding)
- `miss_addr` is stable while `mem_valid=0` and advances by exactly 1 after each accepted byte. It never crosses the 4-byte line boundary.
- If `valid_out=0`, fetch holds `req_pc`; if the cache holds its state across such stalls, no output is lost.

## Configuration
- `ICACHE_FILL_FORWARD_EN` defined:
  - In the cycle the 4th byte is accepted, if `cur_pc[31:2]==fill_addr[31:2]`, then `valid_out=1` and `inst_out={mem_byte, buf[23:0]}` (critical-word bypass).
  - The line is written on the same edge.
- Undefined: no bypass; the word is visible only from the array one cycle later.

## Test plan
- Cold miss at 0x0000_0000, bytes 0x13,0x00,0x00,0x00 on consecutive cycles → `miss_addr` 0,1,2,3 with `miss_req=1`; then `valid_out=1`, `inst_out=0x0000_0013`. Check both macro settings for the N+5/N+6 timing.
- Repeat 0x0000_0000 after fill → hit, `valid_out=1` next cycle, `miss_req` stays 0.
- Aliasing (INDEX_BITS=6): fill 0x0000_0100 with 0xAABBCCDD → index 0 replaced. A subsequent 0x0000_0000 misses; a subsequent 0x0000_0100 hits with 0xAABBCCDD.
- `mem_valid` gaps (byte, idle, idle, byte, byte, byte) → `miss_addr` holds between bytes; assembled word correct; exactly four bytes consumed.
- Redirect during fill of 0x0000_0040 to 0x0000_0080 → fill completes, line 0x40 valid. A new fill then starts with `miss_addr=0x80`. `valid_out` is never asserted for 0x80 with 0x40's data.
- `rst_in` asserted after two bytes of a fill → next cycle `miss_req=0`, `valid_out=0`. A re-request of the same address starts from `miss_addr` byte 0 and previously valid lines miss.

Source files
------------

// File: rtl/direct_mapped_icache.sv
// direct_mapped_icache
//   Direct-mapped instruction cache, one 32-bit word per line, sitting in
//   front of the fetch unit. Lookup is combinational on the PC latched last
//   cycle (cur_pc). A miss starts a byte-serial fill from the memory
//   controller. The four bytes are assembled little-endian and installed
//   into the line.
//
//   Optional feature (define ICACHE_FILL_FORWARD_EN): critical-word bypass.
//   In the cycle the fourth byte arrives, if cur_pc is in the line being
//   filled, the word is presented to fetch directly from the fill buffer.
//
// Ports
//   clk_in     : clock, all state on the rising edge
//   rst_in     : synchronous active-high reset
//   req_pc     : fetch address for the next cycle (bits [1:0] ignored)
//   inst_out   : instruction for cur_pc
//   valid_out  : inst_out is valid this cycle
//   mem_byte   : byte returned by the memory controller
//   mem_valid  : mem_byte is valid this cycle
//   miss_req   : a fill is in progress and a byte is requested
//   miss_addr  : byte address being requested
module direct_mapped_icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] req_pc,
  output logic [31:0] inst_out,
  output logic        valid_out,
  input  logic [7:0]  mem_byte,
  input  logic        mem_valid,
  output logic        miss_req,
  output logic [31:0] miss_addr
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           cur_pc_q, cur_pc_d;
  logic [31:0]           fill_addr_q, fill_addr_d;
  logic [23:0]           buf_q, buf_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] cur_idx, fill_idx;
  logic [TAG_W-1:0]      cur_tag, fill_tag;
  logic                  hit;
  logic                  fill_done;
  logic [31:0]           fill_word;
  logic                  unused_bits;

  assign cur_idx     = cur_pc_q[INDEX_BITS+1:2];
  assign cur_tag     = cur_pc_q[31:INDEX_BITS+2];
  assign fill_idx    = fill_addr_q[INDEX_BITS+1:2];
  assign fill_tag    = fill_addr_q[31:INDEX_BITS+2];
  assign hit         = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign fill_word   = {mem_byte, buf_q};
  assign miss_addr   = {fill_addr_q[31:2], cnt_q};
  // Byte offsets never take part in lookup or fill addressing.
  assign unused_bits = ^{cur_pc_q[1:0], fill_addr_q[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_pc_d    = req_pc;
    fill_addr_d = fill_addr_q;
    buf_d       = buf_q;
    valid_d     = valid_q;
    fill_done   = 1'b0;
    miss_req    = 1'b0;
    valid_out   = hit;
    inst_out    = data_q[cur_idx];

    case (state_q)
      IDLE: begin
        if (!hit) begin
          fill_addr_d = {cur_pc_q[31:2], 2'b00};
          cnt_d       = 2'd0;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Lookup keeps running on cur_pc, so a hit under the miss is served.
        miss_req = 1'b1;
        if (mem_valid) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: buf_d[7:0]   = mem_byte;
            2'd1: buf_d[15:8]  = mem_byte;
            2'd2: buf_d[23:16] = mem_byte;
            default: begin
              fill_done         = 1'b1;
              valid_d[fill_idx] = 1'b1;
              state_d           = IDLE;
`ifdef ICACHE_FILL_FORWARD_EN
              if (cur_pc_q[31:2] == fill_addr_q[31:2]) begin
                valid_out = 1'b1;
                inst_out  = fill_word;
              end
`endif
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      cur_pc_q    <= 32'h0;
      fill_addr_q <= 32'h0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_pc_q    <= cur_pc_d;
      fill_addr_q <= fill_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Line payload and fill buffer are not reset; the valid bits gate them.
  // A reset in the completing cycle discards the line.
  always_ff @(posedge clk_in) begin
    buf_q <= buf_d;
    if (fill_done && !rst_in) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_word;
    end
  end

endmodule

// File: tb/tb_direct_mapped_icache.sv
module tb_direct_mapped_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] req_pc;
  logic [31:0] inst_out;
  logic        valid_out;
  logic [7:0]  mem_byte;
  logic        mem_valid;
  logic        miss_req;
  logic [31:0] miss_addr;

  int checks   = 0;
  int failures = 0;

`ifdef ICACHE_FILL_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  direct_mapped_icache #(.INDEX_BITS(6)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_pc    (req_pc),
    .inst_out  (inst_out),
    .valid_out (valid_out),
    .mem_byte  (mem_byte),
    .mem_valid (mem_valid),
    .miss_req  (miss_req),
    .miss_addr (miss_addr)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_in);
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    mem_valid = v;
    mem_byte  = b;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; req_pc = 32'h0; drive(1'b0, 8'h00);
    repeat (3) tick();
    smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
    checks++; if (miss_req !== 1'b0) begin failures++; $display("FAIL reset_miss_req got=%b want=0", miss_req); end
    checks++; if (miss_addr !== 32'h0) begin failures++; $display("FAIL reset_miss_addr got=%h want=00000000", miss_addr); end
  endtask

  task automatic test_cold_miss();
    logic [7:0] b [4];
    b = '{8'h13, 8'h00, 8'h00, 8'h00};
    tick(); rst_in = 1'b0; req_pc = 32'h0; smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL cold_miss_cycle_valid got=%b want=0", valid_out); end
    checks++; if (miss_req !== 1'b0) begin failures++; $display("FAIL cold_miss_cycle_req got=%b want=0", miss_req); end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, b[k]); smp();
      checks++; if (miss_req !== 1'b1) begin failures++; $display("FAIL cold_req byte%0d got=%b want=1", k, miss_req); end
      checks++; if (miss_addr !== 32'(k)) begin failures++; $display("FAIL cold_addr byte%0d got=%h want=%h", k, miss_addr, 32'(k)); end
      checks++; if (valid_out !== ((k == 3) ? FWD : 1'b0)) begin failures++; $display("FAIL cold_valid byte%0d got=%b want=%b", k, valid_out, (k == 3) ? FWD : 1'b0); end
      checks++; if (valid_out && inst_out !== 32'h0000_0013) begin failures++; $display("FAIL cold_fwd_inst got=%h want=00000013", inst_out); end
    end
    tick(); drive(1'b0, 8'h00); smp();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL cold_done_valid got=%b want=1", valid_out); end
    checks++; if (inst_out !== 32'h0000_0013) begin failures++; $display("FAIL cold_done_inst got=%h want=00000013", inst_out); end
    checks++; if (miss_req !== 1'b0) begin failures++; $display("FAIL cold_done_req got=%b want=0", miss_req); end
  endtask

  task automatic test_hit_repeat();
    for (int k = 0; k < 3; k++) begin
      tick(); req_pc = 32'h0; smp();
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL hit_valid cyc%0d got=%b want=1", k, valid_out); end
      checks++; if (inst_out !== 32'h0000_0013) begin failures++; $display("FAIL hit_inst cyc%0d got=%h want=00000013", k, inst_out); end
      checks++; if (miss_req !== 1'b0) begin failures++; $display("FAIL hit_req cyc%0d got=%b want=0", k, miss_req); end
    end
  endtask

  task automatic test_alias();
    logic [7:0] b [4];
    logic [7:0] z [4];
    b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    z = '{8'h13, 8'h00, 8'h00, 8'h00};
    tick(); req_pc = 32'h100; smp();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL alias_pre_hit got=%b want=1", valid_out); end
    tick(); smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL alias_100_miss got=%b want=0", valid_out); end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, b[k]); smp();
      checks++; if (miss_addr !== 32'h100 + 32'(k)) begin failures++; $display("FAIL alias_addr byte%0d got=%h want=%h", k, miss_addr, 32'h100 + 32'(k)); end
      checks++; if (valid_out !== ((k == 3) ? FWD : 1'b0)) begin failures++; $display("FAIL alias_valid byte%0d got=%b want=%b", k, valid_out, (k == 3) ? FWD : 1'b0); end
      checks++; if (valid_out && inst_out !== 32'hAABB_CCDD) begin failures++; $display("FAIL alias_fwd_inst got=%h want=aabbccdd", inst_out); end
    end
    tick(); drive(1'b0, 8'h00); req_pc = 32'h0; smp();
    checks++; if (valid_out !== 1'b1 || inst_out !== 32'hAABB_CCDD) begin failures++; $display("FAIL alias_100_hit got=%b/%h want=1/aabbccdd", valid_out, inst_out); end
    tick(); smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL alias_000_miss got=%b want=0", valid_out); end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, z[k]); smp();
      checks++; if (miss_req !== 1'b1 || miss_addr !== 32'(k)) begin failures++; $display("FAIL alias_refill byte%0d got=%b/%h want=1/%h", k, miss_req, miss_addr, 32'(k)); end
    end
    tick(); drive(1'b0, 8'h00); smp();
    checks++; if (valid_out !== 1'b1 || inst_out !== 32'h0000_0013) begin failures++; $display("FAIL alias_refill_hit got=%b/%h want=1/00000013", valid_out, inst_out); end
  endtask

  task automatic test_gaps();
    logic       v [6];
    logic [7:0] b [6];
    logic [31:0] a [6];
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    b = '{8'h78, 8'hEE, 8'hEE, 8'h56, 8'h34, 8'h12};
    a = '{32'h8, 32'h9, 32'h9, 32'h9, 32'hA, 32'hB};
    tick(); req_pc = 32'h8; smp();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL gaps_pre_hit got=%b want=1", valid_out); end
    tick(); smp();
    checks++; if (valid_out !== 1'b0 || miss_req !== 1'b0) begin failures++; $display("FAIL gaps_miss_cycle got=%b/%b want=0/0", valid_out, miss_req); end
    for (int k = 0; k < 6; k++) begin
      tick(); drive(v[k], b[k]); smp();
      checks++; if (miss_req !== 1'b1) begin failures++; $display("FAIL gaps_req step%0d got=%b want=1", k, miss_req); end
      checks++; if (miss_addr !== a[k]) begin failures++; $display("FAIL gaps_addr step%0d got=%h want=%h", k, miss_addr, a[k]); end
      checks++; if (valid_out !== ((k == 5) ? FWD : 1'b0)) begin failures++; $display("FAIL gaps_valid step%0d got=%b want=%b", k, valid_out, (k == 5) ? FWD : 1'b0); end
      checks++; if (valid_out && inst_out !== 32'h1234_5678) begin failures++; $display("FAIL gaps_fwd_inst got=%h want=12345678", inst_out); end
    end
    // Extra mem_valid pulses after the fill must not be consumed.
    for (int k = 0; k < 2; k++) begin
      tick(); drive(1'b1, 8'h99); smp();
      checks++; if (miss_req !== 1'b0) begin failures++; $display("FAIL gaps_post_req cyc%0d got=%b want=0", k, miss_req); end
      checks++; if (valid_out !== 1'b1 || inst_out !== 32'h1234_5678) begin failures++; $display("FAIL gaps_post_hit cyc%0d got=%b/%h want=1/12345678", k, valid_out, inst_out); end
    end
  endtask

  task automatic test_redirect();
    logic [7:0] b40 [4];
    logic [7:0] b80 [4];
    b40 = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
    b80 = '{8'h44, 8'h33, 8'h22, 8'h11};
    tick(); drive(1'b0, 8'h00); req_pc = 32'h40; smp();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL redir_pre_hit got=%b want=1", valid_out); end
    tick(); smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL redir_40_miss got=%b want=0", valid_out); end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, b40[k]); if (k == 0) req_pc = 32'h80; smp();
      checks++; if (miss_req !== 1'b1 || miss_addr !== 32'h40 + 32'(k)) begin failures++; $display("FAIL redir_fill40 byte%0d got=%b/%h want=1/%h", k, miss_req, miss_addr, 32'h40 + 32'(k)); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL redir_no_valid byte%0d got=%b want=0", k, valid_out); end
    end
    tick(); drive(1'b0, 8'h00); smp();
    checks++; if (valid_out !== 1'b0 || miss_req !== 1'b0) begin failures++; $display("FAIL redir_80_miss got=%b/%b want=0/0", valid_out, miss_req); end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, b80[k]); if (k == 0) req_pc = 32'h40; smp();
      checks++; if (miss_req !== 1'b1 || miss_addr !== 32'h80 + 32'(k)) begin failures++; $display("FAIL redir_fill80 byte%0d got=%b/%h want=1/%h", k, miss_req, miss_addr, 32'h80 + 32'(k)); end
      checks++; if (valid_out !== (k != 0)) begin failures++; $display("FAIL redir_hum_valid byte%0d got=%b want=%b", k, valid_out, k != 0); end
      checks++; if (valid_out && inst_out !== 32'h0BAD_F00D) begin failures++; $display("FAIL redir_hum_inst byte%0d got=%h want=0badf00d", k, inst_out); end
    end
    tick(); drive(1'b0, 8'h00); req_pc = 32'h80; smp();
    checks++; if (valid_out !== 1'b1 || inst_out !== 32'h0BAD_F00D || miss_req !== 1'b0) begin failures++; $display("FAIL redir_40_hit got=%b/%h/%b want=1/0badf00d/0", valid_out, inst_out, miss_req); end
    tick(); smp();
    checks++; if (valid_out !== 1'b1 || inst_out !== 32'h1122_3344) begin failures++; $display("FAIL redir_80_hit got=%b/%h want=1/11223344", valid_out, inst_out); end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] z [4];
    logic [7:0] c [4];
    z = '{8'h13, 8'h00, 8'h00, 8'h00};
    c = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    tick(); req_pc = 32'h0C; smp();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL rmf_pre_hit got=%b want=1", valid_out); end
    tick(); smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmf_0c_miss got=%b want=0", valid_out); end
    for (int k = 0; k < 2; k++) begin
      tick(); drive(1'b1, 8'hA0 + 8'(k)); smp();
      checks++; if (miss_addr !== 32'h0C + 32'(k)) begin failures++; $display("FAIL rmf_part byte%0d got=%h want=%h", k, miss_addr, 32'h0C + 32'(k)); end
    end
    tick(); drive(1'b0, 8'h00); rst_in = 1'b1; smp();
    checks++; if (miss_req !== 1'b1 || miss_addr !== 32'h0E) begin failures++; $display("FAIL rmf_before_rst got=%b/%h want=1/0000000e", miss_req, miss_addr); end
    tick(); rst_in = 1'b0; smp();
    checks++; if (miss_req !== 1'b0 || valid_out !== 1'b0 || miss_addr !== 32'h0) begin failures++; $display("FAIL rmf_after_rst got=%b/%b/%h want=0/0/00000000", miss_req, valid_out, miss_addr); end
    // Reset left cur_pc at 0, and line 0 lost its valid bit, so it refills first.
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, z[k]); smp();
      checks++; if (miss_req !== 1'b1 || miss_addr !== 32'(k)) begin failures++; $display("FAIL rmf_line0 byte%0d got=%b/%h want=1/%h", k, miss_req, miss_addr, 32'(k)); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmf_line0_valid byte%0d got=%b want=0", k, valid_out); end
    end
    tick(); drive(1'b0, 8'h00); smp();
    checks++; if (valid_out !== 1'b0 || miss_req !== 1'b0) begin failures++; $display("FAIL rmf_0c_remiss got=%b/%b want=0/0", valid_out, miss_req); end
    for (int k = 0; k < 4; k++) begin
      tick(); drive(1'b1, c[k]); smp();
      checks++; if (miss_req !== 1'b1 || miss_addr !== 32'h0C + 32'(k)) begin failures++; $display("FAIL rmf_refill byte%0d got=%b/%h want=1/%h", k, miss_req, miss_addr, 32'h0C + 32'(k)); end
      checks++; if (valid_out !== ((k == 3) ? FWD : 1'b0)) begin failures++; $display("FAIL rmf_refill_valid byte%0d got=%b want=%b", k, valid_out, (k == 3) ? FWD : 1'b0); end
    end
    tick(); drive(1'b0, 8'h00); req_pc = 32'h8; smp();
    checks++; if (valid_out !== 1'b1 || inst_out !== 32'hB3B2_B1B0) begin failures++; $display("FAIL rmf_0c_hit got=%b/%h want=1/b3b2b1b0", valid_out, inst_out); end
    tick(); smp();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmf_line8_cleared got=%b want=0", valid_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_repeat();
    test_alias();
    test_gaps();
    test_redirect();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
